// File: rtl/cnt_int_unit_if.sv
// Decode-side bundle for the counter/interrupt unit.
// Build with CNT_INT_OVERRUN_EN to expose the lost-expiry counter.
interface cnt_int_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stallD;
    logic             cnt_int;
    logic             cnt_int_sel;
    logic             cnt_int_disable;
    logic             rti;
    logic             in_delay_slot;
    logic [WIDTH-1:0] rs_valD;
    logic [WIDTH-1:0] pcD;
    logic             int_en1;
    logic [WIDTH-1:0] int_pc;
    logic [WIDTH-1:0] epc;
    logic             in_service;
    logic [1:0]       pending;
`ifdef CNT_INT_OVERRUN_EN
    logic [7:0]       overrun;

    modport master (
        output stallD, cnt_int, cnt_int_sel, cnt_int_disable,
        output rti, in_delay_slot, rs_valD, pcD,
        input  int_en1, int_pc, epc, in_service, pending, overrun
    );

    modport slave (
        input  stallD, cnt_int, cnt_int_sel, cnt_int_disable,
        input  rti, in_delay_slot, rs_valD, pcD,
        output int_en1, int_pc, epc, in_service, pending, overrun
    );
`else
    modport master (
        output stallD, cnt_int, cnt_int_sel, cnt_int_disable,
        output rti, in_delay_slot, rs_valD, pcD,
        input  int_en1, int_pc, epc, in_service, pending
    );

    modport slave (
        input  stallD, cnt_int, cnt_int_sel, cnt_int_disable,
        input  rti, in_delay_slot, rs_valD, pcD,
        output int_en1, int_pc, epc, in_service, pending
    );
`endif
endinterface

// File: rtl/cnt_int_unit.sv
// Two auto-reload down-counters feeding a single-level interrupt FSM.
// Define CNT_INT_OVERRUN_EN to count expiries lost to a set pending bit.
module cnt_int_unit #(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] VEC0  = 32'h0000_0100,
    parameter logic [WIDTH-1:0] VEC1  = 32'h0000_0180
) (
    input logic           clk,
    input logic           reset,
    cnt_int_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        TAKE,
        SERVICE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q [2];
    logic [WIDTH-1:0] per_q [2];
    logic [1:0]       en_q, pend_q;
    logic [1:0]       hit, expire, clr;
    logic             zero_val, take;
    logic [WIDTH-1:0] epc_q, pc_q;
    logic             int_en1_q, svc_q;

    // A config write to a timer masks that timer's expiry this cycle.
    always_comb begin
        hit = 2'b00;
        if (bus.cnt_int && !bus.stallD)
            hit = bus.cnt_int_sel ? 2'b10 : 2'b01;
        zero_val = bus.cnt_int_disable || (bus.rs_valD == '0);
        for (int i = 0; i < 2; i++)
            expire[i] = en_q[i] && (cnt_q[i] == WIDTH'(1)) && !hit[i];
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|pend_q && !bus.stallD && !bus.in_delay_slot &&
                    !bus.rti && !bus.cnt_int) begin
                    take    = 1'b1;
                    state_d = TAKE;
                end
            end
            TAKE:    if (!bus.stallD) state_d = SERVICE;
            SERVICE: if (bus.rti && !bus.stallD) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        clr = 2'b00;
        if (take) clr = pend_q[0] ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
                per_q[i] <= '0;
            end
            en_q      <= 2'b00;
            pend_q    <= 2'b00;
            epc_q     <= '0;
            pc_q      <= '0;
            int_en1_q <= 1'b0;
            svc_q     <= 1'b0;
        end else begin
            int_en1_q <= (state_d == TAKE);
            svc_q     <= (state_d == SERVICE);
            // New expiry beats the clear from interrupt entry.
            pend_q    <= (pend_q & ~clr) | expire;
            if (take) begin
                epc_q <= bus.pcD;
                pc_q  <= pend_q[0] ? VEC0 : VEC1;
            end
            for (int i = 0; i < 2; i++) begin
                if (hit[i]) begin
                    if (zero_val) begin
                        en_q[i]  <= 1'b0;
                        cnt_q[i] <= '0;
                    end else begin
                        en_q[i]  <= 1'b1;
                        cnt_q[i] <= bus.rs_valD;
                        per_q[i] <= bus.rs_valD;
                    end
                end else if (en_q[i]) begin
                    cnt_q[i] <= expire[i] ? per_q[i] : cnt_q[i] - WIDTH'(1);
                end
            end
        end
    end

    assign bus.int_en1    = int_en1_q;
    assign bus.int_pc     = pc_q;
    assign bus.epc        = epc_q;
    assign bus.in_service = svc_q;
    assign bus.pending    = pend_q;

`ifdef CNT_INT_OVERRUN_EN
    logic [1:0] lost;
    logic [8:0] ovr_sum;
    logic [7:0] ovr_q;

    always_comb begin
        lost    = expire & pend_q & ~clr;
        ovr_sum = {1'b0, ovr_q} + 9'(lost[0]) + 9'(lost[1]);
    end

    always_ff @(posedge clk) begin
        if (reset || |hit) ovr_q <= 8'h00;
        else if (ovr_sum > 9'd255) ovr_q <= 8'hFF;
        else ovr_q <= ovr_sum[7:0];
    end

    assign bus.overrun = ovr_q;
`endif

endmodule

// File: doc/cnt_int_unit.md
Name: cnt_int_unit

Overview:
- Timer/interrupt unit directly upstream of the pipeline controller.
- Consumes the decoded counter-interrupt and return-from-interrupt signals: cnt_int, cnt_int_sel, cnt_int_disable, rti.
- Produces int_en1 and the redirect PC.
- Holds two programmable down-counters and a single-level interrupt state machine.
- Records the return PC (epc) so that rti can resume execution.

Parameters:
- WIDTH, 32, counter, period and PC width.
- VEC0, 32'h0000_0100, handler address for timer 0.
- VEC1, 32'h0000_0180, handler address for timer 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- stallD  in  1  decode stage stalled; no decode-stage action is taken while high.
- cnt_int  in  1  counter-interrupt instruction valid in decode.
- cnt_int_sel  in  1  timer select: 0 = timer0, 1 = timer1.
- cnt_int_disable  in  1  1 = disable the selected timer; 0 = load period and enable it.
- rti  in  1  return-from-interrupt instruction in decode.
- in_delay_slot  in  1  decode instruction is a branch/jump delay slot; blocks interrupt entry.
- rs_valD  in  WIDTH  period operand for cnt_int.
- pcD  in  WIDTH  PC of the decode instruction; this value is captured as epc.
- int_en1  out  1  interrupt redirect request (registered).
- int_pc  out  WIDTH  handler vector; valid while int_en1 = 1.
- epc  out  WIDTH  return PC; used by the fetch mux when rti is taken.
- in_service  out  1  handler currently executing.
- pending  out  2  latched expiries, bit i = timer i.

Behaviour:
- Reset: all of the following clear to 0:
  - counters, periods, enables, pending, epc
  - int_en1, int_pc, in_service
  - state = IDLE
- Config write happens when cnt_int & ~stallD, on the next edge:
  - disable = 1: enable[sel] <= 0, counter[sel] <= 0. pending[sel] is kept.
  - disable = 0 and rs_valD != 0: period[sel] <= rs_valD, counter[sel] <= rs_valD, enable[sel] <= 1.
  - disable = 0 and rs_valD == 0: treated exactly as disable.
  - Config writes are allowed in every state.
- Counting, for each enabled timer every cycle, independent of stalls:
  - If counter == 1: pending[i] <= 1 and counter <= period (auto-reload).
  - Otherwise: counter <= counter - 1.
  - A period of 1 therefore expires every cycle.
  - An expiry while pending[i] is already 1 is lost. Without the optional feature, this loss is silent.
- Simultaneous events:
  - A config write to a timer in the same cycle as that timer's expiry: the write wins and that expiry is dropped.
  - Expiry and pending-clear on the same edge: set wins.
- State machine:
  - IDLE -> TAKE when all of these hold: (pending != 0), ~stallD, ~in_delay_slot, ~rti, ~cnt_int. On this edge:
    - epc <= pcD.
    - Select timer0 if pending[0], else timer1.
    - Clear the selected pending bit.
    - int_pc <= VEC0 or VEC1 accordingly.
    - int_en1 <= 1.
  - TAKE:
    - int_en1 stays 1 while stallD = 1.
    - First cycle with ~stallD -> SERVICE on the next edge; int_en1 <= 0, in_service <= 1.
    - int_en1 is high for at least 1 cycle.
  - SERVICE:
    - Further interrupts are masked; pending bits still accumulate.
    - rti & ~stallD -> IDLE on the next edge, in_service <= 0.
    - Earliest re-entry is the cycle after returning to IDLE.
  - rti seen while in IDLE or TAKE is ignored (no state change).
- Latency: from expiry edge to int_en1 high is at least 2 edges (pending set, then TAKE entry), assuming no stall and no delay slot.
- Reset mid-service returns to IDLE with all state cleared. epc is lost.

Optional Feature:
- Macro: CNT_INT_OVERRUN_EN.
- With the macro defined:
  - Adds output overrun [7:0].
  - Saturating count of expiries lost because the pending bit was already set, summed over both timers.
  - Each timer contributes at most 1 per cycle, so up to +2 per cycle.
  - Holds at 8'hFF.
  - Cleared by reset, and by any cnt_int config write that has ~stallD.
- Without the macro: the port is absent and lost expiries are not counted.

Test Plan:
- Load timer0 with period 5 (cnt_int, sel 0, rs_valD 5, pcD 0x40) and hold pcD = 0x58 -> pending[0] every 5 cycles; first int_en1 within 2 cycles of the expiry; int_pc = 0x100; epc = 0x58.
- Both timers expire on the same cycle (timer0 period 4, timer1 period 4) -> timer0 serviced first; pending = 2'b10 remains; after rti, int_en1 again with int_pc = 0x180.
- Interrupt pending while in_delay_slot = 1 for 3 cycles, then stallD = 1 for 2 cycles -> int_en1 held off; entry on the first cycle with both low; int_en1 stays high through any stall during TAKE.
- Config with rs_valD = 0, or disable = 1 -> counter frozen at 0, no new pending; a previously latched pending bit is still serviced.
- Timer0 period 1 while in SERVICE for 10 cycles -> pending[0] stays 1. With CNT_INT_OVERRUN_EN: overrun = 9 (first expiry sets pending, following 9 lost); then a config write clears it to 0.
- Assert reset during SERVICE -> next cycle: in_service = 0, int_en1 = 0, pending = 0, epc = 0; a subsequent rti has no effect.
